// File: rtl/plot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plot_arbiter_pkg
//  Description : Shared definitions for the Pac-Man plot path: screen size
//                defaults, colour constants, arbiter state encoding and
//                requester identifiers.
//  Revision    : 1.0  initial release
// ============================================================================
package plot_arbiter_pkg;

    // Screen geometry defaults
    localparam int C_SCREEN_W = 160;
    localparam int C_SCREEN_H = 120;

    // 3-bit RGB palette used by the game
    localparam logic [2:0] C_BLACK  = 3'b000;
    localparam logic [2:0] C_BLUE   = 3'b001;
    localparam logic [2:0] C_RED    = 3'b100;
    localparam logic [2:0] C_YELLOW = 3'b110;
    localparam logic [2:0] C_WHITE  = 3'b111;

    // Arbiter state encoding
    typedef enum logic [0:0] {
        S_ARB   = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Requester identifiers, used to remember the most recent winner
    typedef enum logic [0:0] {
        REQ_PAC   = 1'b0,
        REQ_GHOST = 1'b1
    } req_id_t;

endpackage : plot_arbiter_pkg
`default_nettype wire

// File: rtl/plot_arbiter_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_counter
//  Description : Column/row counter that walks every pixel of the screen in
//                raster order. cx wraps at SCREEN_W-1 and advances cy; cy
//                wraps at SCREEN_H-1. 'last' flags the final pixel.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                clr   - zero both counters
//                en    - advance one pixel
//                cx    - current column (8 bits)
//                cy    - current row (7 bits)
//                last  - current position is (SCREEN_W-1, SCREEN_H-1)
//  Revision    : 1.0  initial release
// ============================================================================
module raster_counter
    import plot_arbiter_pkg::*;
#(
    parameter int SCREEN_W = C_SCREEN_W,
    parameter int SCREEN_H = C_SCREEN_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] cx,
    output logic [6:0] cy,
    output logic       last
);

    localparam logic [7:0] C_X_MAX = 8'(SCREEN_W - 1);
    localparam logic [6:0] C_Y_MAX = 7'(SCREEN_H - 1);

    logic [7:0] r_cx;
    logic [6:0] r_cy;
    logic       w_x_wrap;
    logic       w_y_wrap;

    // Explicit terminal-count compares: the screen is not a power of two
    assign w_x_wrap = (r_cx == C_X_MAX);
    assign w_y_wrap = (r_cy == C_Y_MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (en) begin
            if (w_x_wrap) begin
                r_cx <= '0;
                r_cy <= w_y_wrap ? 7'd0 : r_cy + 7'd1;
            end else begin
                r_cx <= r_cx + 8'd1;
            end
        end
    end

    assign cx   = r_cx;
    assign cy   = r_cy;
    assign last = w_x_wrap && w_y_wrap;

endmodule : raster_counter
`default_nettype wire

// File: rtl/plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : plot_arbiter
//  Description : Shares the VGA adapter write port between the Pac-Man
//                drawer, the ghost drawer and a full-screen clear sequencer.
//                Drawers are served one pixel per cycle, round-robin on
//                contention. A clear request owns the port until every
//                pixel has been written with the latched colour.
//  Ports       : clk, reset                - clock, sync active-high reset
//                clear_start/clear_color   - start a fill with this colour
//                clear_busy/clear_done     - fill in progress / last pixel
//                pac_*   (req,x,y,color)   - Pac-Man pixel request, pac_gnt
//                ghost_* (req,x,y,color)   - ghost pixel request, ghost_gnt
//                x, y, plot_color, plot    - registered VGA write port
//  Revision    : 1.0  initial release
// ============================================================================
module plot_arbiter
    import plot_arbiter_pkg::*;
#(
    parameter int SCREEN_W = C_SCREEN_W,
    parameter int SCREEN_H = C_SCREEN_H
) (
    input  logic       clk,
    input  logic       reset,
    // clear sequencer control
    input  logic       clear_start,
    input  logic [2:0] clear_color,
    output logic       clear_busy,
    output logic       clear_done,
    // Pac-Man drawer
    input  logic       pac_req,
    input  logic [7:0] pac_x,
    input  logic [6:0] pac_y,
    input  logic [2:0] pac_color,
    output logic       pac_gnt,
    // ghost drawer
    input  logic       ghost_req,
    input  logic [7:0] ghost_x,
    input  logic [6:0] ghost_y,
    input  logic [2:0] ghost_color,
    output logic       ghost_gnt,
    // VGA adapter write port
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] plot_color,
    output logic       plot
);

    state_t     r_state;
    state_t     w_state_nxt;
    req_id_t    r_last_winner;
    logic [2:0] r_clear_color;

    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_plot_color;
    logic       r_plot;
    logic       r_clear_done;

    logic       w_pac_gnt;
    logic       w_ghost_gnt;
    logic       w_cnt_clr;
    logic       w_cnt_en;
    logic       w_latch_clear;

    logic [7:0] w_cx;
    logic [6:0] w_cy;
    logic       w_last;

    raster_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_raster_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .cx    (w_cx),
        .cy    (w_cy),
        .last  (w_last)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, grants and counter control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pac_gnt     = 1'b0;
        w_ghost_gnt   = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_en      = 1'b0;
        w_latch_clear = 1'b0;

        case (r_state)
            S_ARB: begin
                if (clear_start) begin
                    // The fill takes priority; any pending request waits
                    w_cnt_clr     = 1'b1;
                    w_latch_clear = 1'b1;
                    w_state_nxt   = S_CLEAR;
                end else if (pac_req && (!ghost_req || r_last_winner == REQ_GHOST)) begin
                    w_pac_gnt = 1'b1;
                end else if (ghost_req) begin
                    w_ghost_gnt = 1'b1;
                end
            end
            S_CLEAR: begin
                w_cnt_en = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_ARB;
                end
            end
            default: begin
                w_state_nxt = S_ARB;
            end
        endcase

        // A pixel accepted during reset would be lost, so never grant then
        if (reset) begin
            w_pac_gnt   = 1'b0;
            w_ghost_gnt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output register, winner history and clear colour
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_plot_color  <= '0;
            r_plot        <= 1'b0;
            r_clear_done  <= 1'b0;
            r_clear_color <= '0;
            r_last_winner <= REQ_GHOST;
        end else begin
            r_plot       <= 1'b0;
            r_clear_done <= 1'b0;

            if (w_latch_clear) begin
                r_clear_color <= clear_color;
            end

            if (r_state == S_CLEAR) begin
                r_x          <= w_cx;
                r_y          <= w_cy;
                r_plot_color <= r_clear_color;
                r_plot       <= 1'b1;
                r_clear_done <= w_last;
            end else if (w_pac_gnt) begin
                r_x           <= pac_x;
                r_y           <= pac_y;
                r_plot_color  <= pac_color;
                r_plot        <= 1'b1;
                r_last_winner <= REQ_PAC;
            end else if (w_ghost_gnt) begin
                r_x           <= ghost_x;
                r_y           <= ghost_y;
                r_plot_color  <= ghost_color;
                r_plot        <= 1'b1;
                r_last_winner <= REQ_GHOST;
            end
        end
    end

    assign pac_gnt    = w_pac_gnt;
    assign ghost_gnt  = w_ghost_gnt;
    assign clear_busy = (r_state == S_CLEAR);
    assign clear_done = r_clear_done;
    assign x          = r_x;
    assign y          = r_y;
    assign plot_color = r_plot_color;
    assign plot       = r_plot;

endmodule : plot_arbiter
`default_nettype wire

// File: tb/tb_plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plot_arbiter
//  Description : Self-checking bench for plot_arbiter. A reference model
//                predicts grants and busy each cycle and queues the pixels
//                expected on the VGA port; a monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_plot_arbiter;
    import plot_arbiter_pkg::*;

    typedef struct {
        int         cyc;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        logic       done;
    } exp_t;

    typedef struct {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    localparam int C_NPIX = C_SCREEN_W * C_SCREEN_H;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_start;
    logic [2:0] clear_color;
    logic       clear_busy;
    logic       clear_done;
    logic       pac_req;
    logic [7:0] pac_x;
    logic [6:0] pac_y;
    logic [2:0] pac_color;
    logic       pac_gnt;
    logic       ghost_req;
    logic [7:0] ghost_x;
    logic [6:0] ghost_y;
    logic [2:0] ghost_color;
    logic       ghost_gnt;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] plot_color;
    logic       plot;

    exp_t exp_q[$];
    pix_t pac_q[$];
    pix_t ghost_q[$];

    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    // reference model state
    bit         m_clear      = 1'b0;
    int         m_idx        = 0;
    bit         m_last_ghost = 1'b1;
    logic [2:0] m_col        = 3'd0;

    plot_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .pac_req     (pac_req),
        .pac_x       (pac_x),
        .pac_y       (pac_y),
        .pac_color   (pac_color),
        .pac_gnt     (pac_gnt),
        .ghost_req   (ghost_req),
        .ghost_x     (ghost_x),
        .ghost_y     (ghost_y),
        .ghost_color (ghost_color),
        .ghost_gnt   (ghost_gnt),
        .x           (x),
        .y           (y),
        .plot_color  (plot_color),
        .plot        (plot)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Output monitor: plot must be high exactly when a pixel is due
    always @(negedge clk) begin : mon
        exp_t e;
        bit   want;
        if (mon_en) begin
            want = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
            check_val("plot", 32'(plot), 32'(want));
            if (want) begin
                e = exp_q.pop_front();
                check_val("pixel{x,y,c,done}",
                          {13'd0, x, y, plot_color, clear_done},
                          {13'd0, e.px, e.py, e.pc, e.done});
            end else begin
                check_val("clear_done", 32'(clear_done), 32'd0);
            end
        end
    end

    // One clock of stimulus plus model prediction for that cycle
    task automatic cycle(input logic rs, input logic cs, input logic [2:0] cc);
        bit e_pg;
        bit e_gg;
        bit e_busy;
        @(posedge clk);
        #2;
        reset       = rs;
        clear_start = cs;
        clear_color = cc;
        pac_req     = (pac_q.size() != 0);
        ghost_req   = (ghost_q.size() != 0);
        if (pac_req) begin
            pac_x = pac_q[0].px; pac_y = pac_q[0].py; pac_color = pac_q[0].pc;
        end
        if (ghost_req) begin
            ghost_x = ghost_q[0].px; ghost_y = ghost_q[0].py; ghost_color = ghost_q[0].pc;
        end
        #1;
        e_pg   = 1'b0;
        e_gg   = 1'b0;
        e_busy = m_clear;
        if (rs) begin
            m_clear      = 1'b0;
            m_last_ghost = 1'b1;
        end else if (m_clear) begin
            exp_q.push_back('{cyc + 1, 8'(m_idx % C_SCREEN_W), 7'(m_idx / C_SCREEN_W),
                              m_col, (m_idx == C_NPIX - 1)});
            m_idx++;
            if (m_idx == C_NPIX) m_clear = 1'b0;
        end else if (cs) begin
            m_clear = 1'b1;
            m_idx   = 0;
            m_col   = cc;
        end else if (pac_req && (!ghost_req || m_last_ghost)) begin
            e_pg = 1'b1;
        end else if (ghost_req) begin
            e_gg = 1'b1;
        end
        if (mon_en) begin
            check_val("pac_gnt", 32'(pac_gnt), 32'(e_pg));
            check_val("ghost_gnt", 32'(ghost_gnt), 32'(e_gg));
            check_val("clear_busy", 32'(clear_busy), 32'(e_busy));
        end
        if (e_pg) begin
            exp_q.push_back('{cyc + 1, pac_q[0].px, pac_q[0].py, pac_q[0].pc, 1'b0});
            void'(pac_q.pop_front());
            m_last_ghost = 1'b0;
        end
        if (e_gg) begin
            exp_q.push_back('{cyc + 1, ghost_q[0].px, ghost_q[0].py, ghost_q[0].pc, 1'b0});
            void'(ghost_q.pop_front());
            m_last_ghost = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; clear_start = 1'b0; clear_color = 3'd0;
        pac_req = 1'b0; pac_x = 8'd0; pac_y = 7'd0; pac_color = 3'd0;
        ghost_req = 1'b0; ghost_x = 8'd0; ghost_y = 7'd0; ghost_color = 3'd0;

        cycle(1'b1, 1'b0, 3'd0);
        cycle(1'b1, 1'b0, 3'd0);
        cycle(1'b0, 1'b0, 3'd0);
        check_val("rst_x", 32'(x), 32'd0);
        check_val("rst_y", 32'(y), 32'd0);
        check_val("rst_color", 32'(plot_color), 32'd0);
        check_val("rst_plot", 32'(plot), 32'd0);
        check_val("rst_busy", 32'(clear_busy), 32'd0);
        check_val("rst_done", 32'(clear_done), 32'd0);
        mon_en = 1'b1;

        // Contention straight after reset: Pac-Man wins the first tie
        pac_q.push_back('{8'd3, 7'd4, C_YELLOW});
        pac_q.push_back('{8'd5, 7'd6, C_RED});
        ghost_q.push_back('{8'd100, 7'd50, C_BLUE});
        ghost_q.push_back('{8'd159, 7'd119, C_WHITE});
        repeat (6) cycle(1'b0, 1'b0, 3'd0);

        // Single requests
        pac_q.push_back('{8'd10, 7'd20, C_YELLOW});
        repeat (3) cycle(1'b0, 1'b0, 3'd0);
        ghost_q.push_back('{8'd7, 7'd9, C_RED});
        repeat (3) cycle(1'b0, 1'b0, 3'd0);

        // Full black clear with a ghost request held throughout
        ghost_q.push_back('{8'd42, 7'd17, C_WHITE});
        cycle(1'b0, 1'b1, C_BLACK);
        repeat (C_NPIX + 5) cycle(1'b0, 1'b0, 3'd0);

        // Reset when pixel 500 would be issued
        cycle(1'b0, 1'b1, C_WHITE);
        repeat (500) cycle(1'b0, 1'b0, 3'd0);
        cycle(1'b1, 1'b0, 3'd0);
        repeat (3) cycle(1'b0, 1'b0, 3'd0);

        // Clear and Pac-Man request collide; a mid-fill restart is ignored
        pac_q.push_back('{8'd77, 7'd66, C_YELLOW});
        cycle(1'b0, 1'b1, C_BLUE);
        repeat (1000) cycle(1'b0, 1'b0, 3'd0);
        cycle(1'b0, 1'b1, C_RED);
        repeat (C_NPIX - 990) cycle(1'b0, 1'b0, 3'd0);
        repeat (3) cycle(1'b0, 1'b0, 3'd0);

        @(negedge clk);
        #1;
        check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check_val("pac_q_drained", 32'(pac_q.size()), 32'd0);
        check_val("ghost_q_drained", 32'(ghost_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_plot_arbiter
`default_nettype wire
